// File: rtl/avg_pkg.sv
// Shared types and constants for the vector-to-raster line drawing path.
package avg_pkg;

   localparam int COORD_W   = 13;
   localparam int PT_W      = 15;
   localparam int ERR_W     = 16;
   localparam int E2_W      = 17;
   localparam int PIX_W     = 10;
   localparam int INT_W     = 4;

   localparam int SCR_W_DEF = 640;
   localparam int SCR_H_DEF = 480;
   localparam int X_OFF_DEF = 320;
   localparam int Y_OFF_DEF = 240;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      DRAW
   } state_t;

   typedef logic signed [PT_W-1:0]  pt_t;
   typedef logic signed [ERR_W-1:0] err_t;
   typedef logic signed [E2_W-1:0]  e2_t;

   function automatic pt_t widenCoord(input logic signed [COORD_W-1:0] v);
      return pt_t'(v);
   endfunction

endpackage

// File: rtl/line_rasterizer.sv
// Pops signed vector endpoints from a line queue and walks them with Bresenham,
// emitting on-screen pixels to a framebuffer with a valid/ready handshake.
module line_rasterizer
   import avg_pkg::*;
#(
   parameter int X_OFF = X_OFF_DEF,
   parameter int Y_OFF = Y_OFF_DEF,
   parameter int SCR_W = SCR_W_DEF,
   parameter int SCR_H = SCR_H_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic signed [COORD_W-1:0] qStartX,
   input  logic signed [COORD_W-1:0] qEndX,
   input  logic signed [COORD_W-1:0] qStartY,
   input  logic signed [COORD_W-1:0] qEndY,
   input  logic        [INT_W-1:0]   qIntensity,
   input  logic                      qEmpty,
   output logic                      qRead,
   output logic        [PIX_W-1:0]   pixX,
   output logic        [PIX_W-1:0]   pixY,
   output logic        [INT_W-1:0]   pixIntensity,
   output logic                      pixWrite,
   input  logic                      pixReady,
   output logic                      busy
);

   localparam pt_t  X_OFF_C  = pt_t'(X_OFF);
   localparam pt_t  Y_OFF_C  = pt_t'(Y_OFF);
   localparam pt_t  SCR_W_C  = pt_t'(SCR_W);
   localparam pt_t  SCR_H_C  = pt_t'(SCR_H);
   localparam pt_t  PT_ONE   = pt_t'(1);
   localparam err_t ERR_ZERO = err_t'(0);

   state_t           state_q, state_d;
   pt_t              xs_q, xs_d, ys_q, ys_d;
   pt_t              xe_q, xe_d, ye_q, ye_d;
   pt_t              x_q, x_d, y_q, y_d;
   err_t             dx_q, dx_d, dy_q, dy_d;
   err_t             err_q, err_d;
   logic             negX_q, negX_d, negY_q, negY_d;
   logic [INT_W-1:0] inten_q, inten_d;

   err_t diffX, diffY, absX, absY, errStep;
   e2_t  e2;
   logic stepX, stepY, atEnd, visible, advance;

   always_comb begin
      diffX   = err_t'(xe_q) - err_t'(xs_q);
      diffY   = err_t'(ye_q) - err_t'(ys_q);
      absX    = diffX[ERR_W-1] ? -diffX : diffX;
      absY    = diffY[ERR_W-1] ? -diffY : diffY;
      e2      = {err_q, 1'b0};
      stepX   = (e2 >= e2_t'(dy_q));
      stepY   = (e2 <= e2_t'(dx_q));
      errStep = err_q + (stepX ? dy_q : ERR_ZERO) + (stepY ? dx_q : ERR_ZERO);
      atEnd   = (x_q == xe_q) && (y_q == ye_q);
      visible = !x_q[PT_W-1] && (x_q < SCR_W_C) &&
                !y_q[PT_W-1] && (y_q < SCR_H_C) &&
                (inten_q != '0);
   end

   // Suppressed points never wait on the framebuffer; written points wait for ready.
   assign advance      = !visible || pixReady;
   assign busy         = (state_q != IDLE);
   assign pixWrite     = (state_q == DRAW) && visible;
   assign pixX         = pixWrite ? x_q[PIX_W-1:0] : '0;
   assign pixY         = pixWrite ? y_q[PIX_W-1:0] : '0;
   assign pixIntensity = pixWrite ? inten_q : '0;

   always_comb begin
      state_d = state_q;
      xs_d    = xs_q;
      ys_d    = ys_q;
      xe_d    = xe_q;
      ye_d    = ye_q;
      x_d     = x_q;
      y_d     = y_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      err_d   = err_q;
      negX_d  = negX_q;
      negY_d  = negY_q;
      inten_d = inten_q;
      qRead   = 1'b0;

      case (state_q)
         IDLE: begin
            // Gated by rst so the queue head survives a reset held over it.
            if (!qEmpty && !rst) begin
               qRead   = 1'b1;
               xs_d    = widenCoord(qStartX) + X_OFF_C;
               xe_d    = widenCoord(qEndX) + X_OFF_C;
               ys_d    = Y_OFF_C - widenCoord(qStartY);
               ye_d    = Y_OFF_C - widenCoord(qEndY);
               inten_d = qIntensity;
               state_d = SETUP;
            end
         end

         SETUP: begin
            dx_d    = absX;
            dy_d    = -absY;
            err_d   = absX - absY;
            negX_d  = diffX[ERR_W-1];
            negY_d  = diffY[ERR_W-1];
            x_d     = xs_q;
            y_d     = ys_q;
            state_d = DRAW;
         end

         DRAW: begin
            if (advance) begin
               if (atEnd) begin
                  state_d = IDLE;
               end else begin
                  err_d = errStep;
                  if (stepX) x_d = negX_q ? x_q - PT_ONE : x_q + PT_ONE;
                  if (stepY) y_d = negY_q ? y_q - PT_ONE : y_q + PT_ONE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         xs_q    <= '0;
         ys_q    <= '0;
         xe_q    <= '0;
         ye_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         err_q   <= '0;
         negX_q  <= 1'b0;
         negY_q  <= 1'b0;
         inten_q <= '0;
      end else begin
         state_q <= state_d;
         xs_q    <= xs_d;
         ys_q    <= ys_d;
         xe_q    <= xe_d;
         ye_q    <= ye_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         err_q   <= err_d;
         negX_q  <= negX_d;
         negY_q  <= negY_d;
         inten_q <= inten_d;
      end
   end

endmodule
